cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Purpose  : Arbitrates I$ and D$ miss traffic onto one downstream memory
//            port. D$ has fixed priority. An I$ fetch can be aborted: the
//            downstream access still runs to completion, but its data is
//            dropped. Defining CACHE_ARB_RR_EN adds a window counter that
//            lets a waiting I$ win a tie after RR_WINDOW back-to-back D$
//            grants.
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
  parameter int WORD_W    = 32,
  parameter int RR_WINDOW = 4
) (
  input  logic              clk,
  input  logic              rst,
  // instruction cache side
  input  logic [WORD_W-1:0] i_addr,
  input  logic              i_ren,
  output logic              i_busy,
  output logic [WORD_W-1:0] i_rdata,
  input  logic              abort_bus,
  // data cache side
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [3:0]        d_byte_en,
  output logic              d_busy,
  output logic [WORD_W-1:0] d_rdata,
  // downstream memory side
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [3:0]        mem_byte_en,
  input  logic              mem_busy,
  input  logic [WORD_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_GNT_D       = 2'd1,
    ST_GNT_I       = 2'd2,
    ST_ABORT_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD_W-1:0] r_i_rdata;
  logic [WORD_W-1:0] r_d_rdata;
  logic [WORD_W-1:0] r_drain_addr;
  logic              w_d_req;
  logic              w_i_wins;
  logic              w_d_done;
  logic              w_i_done;

  assign w_d_req = d_ren | d_wen;

`ifdef CACHE_ARB_RR_EN
  localparam int                 c_CNT_W  = $clog2(RR_WINDOW + 1);
  localparam logic [c_CNT_W-1:0] c_WINDOW = c_CNT_W'(RR_WINDOW);

  logic [c_CNT_W-1:0] r_d_cnt;
  logic               w_d_grant;
  logic               w_i_grant;

  assign w_d_grant = (r_state == ST_IDLE) && (w_state_nxt == ST_GNT_D);
  assign w_i_grant = (r_state == ST_IDLE) && (w_state_nxt == ST_GNT_I);
  // Once the window is used up a pending I$ takes the next tie.
  assign w_i_wins  = i_ren && (r_d_cnt == c_WINDOW);

  // Saturating count of consecutive D$ grants issued while I$ was waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_cnt <= '0;
    end else if (w_i_grant) begin
      r_d_cnt <= '0;
    end else if (w_d_grant) begin
      if (!i_ren) begin
        r_d_cnt <= '0;
      end else if (r_d_cnt != c_WINDOW) begin
        r_d_cnt <= r_d_cnt + c_CNT_W'(1);
      end
    end
  end
`else
  assign w_i_wins = 1'b0;
`endif

  // State register, read-data holding registers and drain address capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_drain_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_i_done) r_i_rdata <= mem_rdata;
      if (w_d_done) r_d_rdata <= mem_rdata;
      // Address of the fetch being drained must not follow a changing i_addr.
      if (r_state == ST_GNT_I) r_drain_addr <= i_addr;
    end
  end

  // Next-state, downstream request and completion decode.
  always_comb begin
    w_state_nxt = r_state;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_byte_en = 4'h0;
    w_d_done    = 1'b0;
    w_i_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_d_req && !w_i_wins) begin
          w_state_nxt = ST_GNT_D;
        end else if (i_ren) begin
          w_state_nxt = ST_GNT_I;
        end
      end
      ST_GNT_D: begin
        // Write wins if the D$ ever raises both strobes, keeping them exclusive.
        mem_wen     = d_wen;
        mem_ren     = d_ren & ~d_wen;
        mem_addr    = d_addr;
        mem_wdata   = d_wdata;
        mem_byte_en = d_byte_en;
        if (!mem_busy) begin
          w_d_done    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GNT_I: begin
        // I$ only reads; request stays up for the whole granted access.
        mem_ren     = 1'b1;
        mem_addr    = i_addr;
        mem_byte_en = 4'hF;
        if (!mem_busy) begin
          w_i_done    = ~abort_bus;
          w_state_nxt = ST_IDLE;
        end else if (abort_bus) begin
          w_state_nxt = ST_ABORT_DRAIN;
        end
      end
      ST_ABORT_DRAIN: begin
        mem_ren     = 1'b1;
        mem_addr    = r_drain_addr;
        mem_byte_en = 4'hF;
        if (!mem_busy) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign d_busy  = ~w_d_done;
  assign i_busy  = ~w_i_done;
  assign d_rdata = w_d_done ? mem_rdata : r_d_rdata;
  assign i_rdata = w_i_done ? mem_rdata : r_i_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_mem_arbiter
// Purpose  : Self-checking bench for cache_mem_arbiter. A memory responder
//            returns addr ^ c_KEY after a programmable number of wait cycles;
//            expected read data is queued per port and checked on completion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

  localparam logic [31:0] c_KEY = 32'hCAFEF10D;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        i_ren, i_busy, abort_bus, d_ren, d_wen, d_busy;
  logic        mem_ren, mem_wen, mem_busy;
  logic [3:0]  d_byte_en, mem_byte_en;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wait_cfg = 0;
  int wcnt    = 0;
  int act_cyc = 0;
  int d_done  = 0;
  int i_done  = 0;
  int d_cyc   = 0;
  int i_cyc   = 0;
  logic        mon_en = 1'b0;
  logic [3:0]  wr_be = 4'h0;
  logic [3:0]  rd_be = 4'h0;
  logic [31:0] wr_data = 32'h0;
  logic [31:0] exp_d, exp_i;
  logic [31:0] d_q[$];
  logic [31:0] i_q[$];

  cache_mem_arbiter #(.WORD_W(32), .RR_WINDOW(4)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_ren(i_ren), .i_busy(i_busy), .i_rdata(i_rdata),
    .abort_bus(abort_bus),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ren(d_ren), .d_wen(d_wen),
    .d_byte_en(d_byte_en), .d_busy(d_busy), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .mem_byte_en(mem_byte_en), .mem_busy(mem_busy),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign mem_rdata = mem_addr ^ c_KEY;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input bit is_i, input int target, input string tag);
    int k = 0;
    while (((is_i ? i_done : d_done) < target) && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(tag, 32'(is_i ? i_done : d_done), 32'(target));
  endtask

  task automatic check_reset_outs();
    check("rst_i_busy", {31'b0, i_busy}, 32'd1);
    check("rst_d_busy", {31'b0, d_busy}, 32'd1);
    check("rst_mem_ren", {31'b0, mem_ren}, 32'd0);
    check("rst_mem_wen", {31'b0, mem_wen}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_be", {28'b0, mem_byte_en}, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
  endtask

  // Memory responder: busy for wait_cfg cycles of an access, then one ready cycle.
  initial begin
    mem_busy = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if ((mem_ren | mem_wen) === 1'b1) begin
        mem_busy = (wcnt < wait_cfg);
        wcnt++;
      end else begin
        mem_busy = 1'b1;
        wcnt = 0;
      end
    end
  end

  // Monitor: exclusivity, activity counting and scoreboard pops on completion.
  always @(negedge clk) begin
    if (mon_en) begin
      check("mem_excl", {31'b0, mem_ren & mem_wen}, 32'd0);
      if (mem_ren | mem_wen) act_cyc++;
      if (mem_wen && !mem_busy) begin
        wr_be   = mem_byte_en;
        wr_data = mem_wdata;
      end
      if (mem_ren) rd_be = mem_byte_en;
      if (!d_busy) begin
        if (d_q.size() != 0) exp_d = d_q.pop_front();
        else exp_d = 32'hxxxxxxxx;
        check("d_rdata", d_rdata, exp_d);
        d_done++;
        d_cyc = cyc;
      end
      if (!i_busy) begin
        if (i_q.size() != 0) exp_i = i_q.pop_front();
        else exp_i = 32'hxxxxxxxx;
        check("i_rdata", i_rdata, exp_i);
        i_done++;
        i_cyc = cyc;
      end
    end
  end

  initial begin
    int t0, a0, db, ib;
    rst = 1'b1; i_addr = '0; i_ren = 1'b0; abort_bus = 1'b0;
    d_addr = '0; d_wdata = '0; d_ren = 1'b0; d_wen = 1'b0; d_byte_en = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs();
    tick();
    rst = 1'b0;
    mon_en = 1'b1;

    // Single D$ read, zero wait states, issued in the first cycle after reset.
    wait_cfg = 0;
    d_addr = 32'h100; d_ren = 1'b1;
    d_q.push_back(32'hCAFEF00D);
    t0 = cyc;
    wait_cnt(1'b0, 1, "t1_done");
    check("t1_latency", 32'(d_cyc - t0 + 1), 32'd2);
    d_ren = 1'b0;
    @(negedge clk);
    check("t1_busy_one_cycle", {31'b0, d_busy}, 32'd1);
    check("t1_d_hold", d_rdata, 32'hCAFEF00D);

    // D$ write and I$ read tie: D$ first, then I$.
    wait_cfg = 1;
    tick();
    d_addr = 32'h140; d_wdata = 32'h12345678; d_byte_en = 4'b0011; d_wen = 1'b1;
    i_addr = 32'h180; i_ren = 1'b1;
    d_q.push_back(32'h140 ^ c_KEY);
    i_q.push_back(32'h180 ^ c_KEY);
    db = d_done; ib = i_done;
    wait_cnt(1'b0, db + 1, "t2_d_done");
    d_wen = 1'b0;
    wait_cnt(1'b1, ib + 1, "t2_i_done");
    i_ren = 1'b0;
    check("t2_order", {31'b0, d_cyc < i_cyc}, 32'd1);
    check("t2_wr_be", {28'b0, wr_be}, 32'h3);
    check("t2_wr_data", wr_data, 32'h12345678);
    check("t2_i_be", {28'b0, rd_be}, 32'hF);

    // I$ fetch aborted mid-access: request held to completion, data dropped.
    wait_cfg = 5;
    tick();
    i_addr = 32'h200; i_ren = 1'b1;
    a0 = act_cyc; ib = i_done;
    tick();
    tick();
    abort_bus = 1'b1; i_ren = 1'b0;
    tick();
    abort_bus = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!mem_ren) break;
    end
    check("t3_ren_cycles", 32'(act_cyc - a0), 32'd6);
    check("t3_no_i_done", 32'(i_done), 32'(ib));
    check("t3_i_hold", i_rdata, 32'h180 ^ c_KEY);

    // Abort coinciding with completion still discards the data.
    wait_cfg = 2;
    tick();
    i_addr = 32'h240; i_ren = 1'b1;
    a0 = act_cyc; ib = i_done;
    tick();
    tick();
    tick();
    abort_bus = 1'b1; i_ren = 1'b0;
    tick();
    abort_bus = 1'b0;
    repeat (2) tick();
    check("t3b_ren_cycles", 32'(act_cyc - a0), 32'd3);
    check("t3b_no_i_done", 32'(i_done), 32'(ib));

    // Abort in GNT_D is ignored; an I$ request dropped before grant is ignored.
    wait_cfg = 2;
    d_addr = 32'h1C0; d_ren = 1'b1; i_addr = 32'h280; i_ren = 1'b1;
    d_q.push_back(32'h1C0 ^ c_KEY);
    a0 = act_cyc; db = d_done; ib = i_done;
    tick();
    i_ren = 1'b0; abort_bus = 1'b1;
    tick();
    abort_bus = 1'b0;
    wait_cnt(1'b0, db + 1, "t4_d_done");
    d_ren = 1'b0;
    repeat (4) tick();
    check("t4_no_i_done", 32'(i_done), 32'(ib));
    check("t4_act_cycles", 32'(act_cyc - a0), 32'd3);

    // Reset on the third wait cycle of a D$ read.
    wait_cfg = 10;
    d_addr = 32'h400; d_ren = 1'b1;
    db = d_done;
    repeat (3) tick();
    rst = 1'b1; d_ren = 1'b0;
    tick();
    @(negedge clk);
    check_reset_outs();
    tick();
    rst = 1'b0;
    repeat (2) tick();
    check("t5_no_d_done", 32'(d_done), 32'(db));

    // Continuous D$ and I$ requests.
    wait_cfg = 0;
    d_addr = 32'h300; d_ren = 1'b1; i_addr = 32'h340; i_ren = 1'b1;
    db = d_done; ib = i_done;
`ifdef CACHE_ARB_RR_EN
    for (int k = 0; k < 4; k++) d_q.push_back(32'h300 ^ c_KEY);
    i_q.push_back(32'h340 ^ c_KEY);
    wait_cnt(1'b1, ib + 1, "t6_i_granted");
    d_ren = 1'b0; i_ren = 1'b0;
    check("t6_d_before_i", 32'(d_done - db), 32'd4);
`else
    for (int k = 0; k < 6; k++) d_q.push_back(32'h300 ^ c_KEY);
    wait_cnt(1'b0, db + 6, "t6_d_grants");
    d_ren = 1'b0; i_ren = 1'b0;
    check("t6_i_starved", 32'(i_done - ib), 32'd0);
`endif
    repeat (3) tick();
    check("sb_d_empty", 32'(d_q.size()), 32'd0);
    check("sb_i_empty", 32'(i_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
